// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls three pipes, respawns them with LFSR gap rows, keeps score
// and raises a sticky hit flag on bird/pipe or bird/floor contact.
module pipe_scroller #(
    parameter int PIPE_SPACING = 220,
    parameter int PIPE_HALF_W  = 25,
    parameter int BIRD_X       = 250,
    parameter int BIRD_HALF_W  = 15,
    parameter int BIRD_HALF_H  = 12,
    parameter int SPEED        = 2,
    parameter int ROW_MIN      = 112,
    parameter int FLOOR_ROW    = 480,
    parameter logic [8:0] LFSR_SEED = 9'h1A5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [2:0] state,
    input  logic [7:0] height,
    input  logic [8:0] birdrow,
    output logic [9:0] column0,
    output logic [9:0] column1,
    output logic [9:0] column2,
    output logic [8:0] row0,
    output logic [8:0] row1,
    output logic [8:0] row2,
    output logic [5:0] score,
    output logic       score_pulse,
    output logic       hit
);
    typedef enum logic [1:0] {LOAD, RUN, FREEZE} mode_t;
    localparam logic signed [10:0] BX_S    = 11'(BIRD_X);
    localparam logic signed [10:0] BHH_S   = 11'(BIRD_HALF_H);
    localparam logic signed [10:0] OW_S    = 11'(PIPE_HALF_W + BIRD_HALF_W);
    localparam logic signed [10:0] FLOOR_S = 11'(FLOOR_ROW);
    mode_t mode, mode_next;
    logic [8:0] lfsr;
    logic [9:0] col [3];
    logic [8:0] row [3];
    logic [9:0] col_nxt [3];
    logic [8:0] row_nxt [3];
    logic [2:0] respawn;
    logic pass, crash;
    assign column0 = col[0];
    assign column1 = col[1];
    assign column2 = col[2];
    assign row0 = row[0];
    assign row1 = row[1];
    assign row2 = row[2];
    always_ff @(posedge clk or posedge rst)
        if (rst) mode <= LOAD;
        else mode <= mode_next;
    always_comb
        mode_next = (state == 3'b011 || state == 3'b110) ? RUN :
                    (state == 3'b100 || state == 3'b101) ? FREEZE : LOAD;
    // Per-pipe move/respawn, scoring and collision, all from pre-move values
    always_comb begin
        logic signed [10:0] br, h2, dx, top, bot;
        br = $signed({2'b0, birdrow});
        h2 = $signed({3'b0, height}) >>> 1;
        pass = 1'b0;
        crash = br + BHH_S >= FLOOR_S;
        for (int k = 0; k < 3; k++) begin
            respawn[k] = col[k] < 10'(PIPE_HALF_W + SPEED);
            col_nxt[k] = respawn[k] ? col[k] + 10'(3 * PIPE_SPACING - SPEED) : col[k] - 10'(SPEED);
            row_nxt[k] = respawn[k] ? 9'(ROW_MIN) + {1'b0, lfsr[7:0]} : row[k];
            pass = pass | (!respawn[k] && col[k] >= 10'(BIRD_X) && col_nxt[k] < 10'(BIRD_X));
            dx = $signed({1'b0, col[k]}) - BX_S;
            top = $signed({2'b0, row[k]}) - h2;
            bot = $signed({2'b0, row[k]}) + h2;
            crash = crash | (dx < OW_S && dx > -OW_S && (br - BHH_S < top || br + BHH_S > bot));
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
            for (int k = 0; k < 3; k++) begin
                col[k] <= 10'((k + 2) * PIPE_SPACING);
                row[k] <= 9'(ROW_MIN + 128);
            end
            score <= '0;
            score_pulse <= 1'b0;
            hit <= 1'b0;
        end else begin
            lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
            score_pulse <= 1'b0;
            if (mode == LOAD) begin
                for (int k = 0; k < 3; k++) begin
                    col[k] <= 10'((k + 2) * PIPE_SPACING);
                    row[k] <= 9'(ROW_MIN + 128);
                end
                score <= '0;
                hit <= 1'b0;
            end else if (mode == RUN && frame_tick) begin
                col <= col_nxt;
                row <= row_nxt;
                hit <= hit | crash;
                if (pass && score != 6'd63) begin
                    score <= score + 6'd1;
                    score_pulse <= 1'b1;
                end
            end
        end
    end
endmodule
